// File: rtl/prog_clkdiv_pkg.sv
// Shared constants for the programmable clock divider.
//   CH_IDX_W  : width of the channel index used by the configuration port.
//   DIV_CLAMP : smallest usable divisor; a programmed divisor below it
//               (i.e. zero) behaves as this value.
package prog_clkdiv_pkg;
  localparam int CH_IDX_W  = 4;
  localparam int DIV_CLAMP = 1;
endpackage

// File: rtl/prog_clock_divider_channel.sv
// One divider channel: counts enabled cycles up to the terminal count of its
// active divisor, emitting a one-cycle tick and toggling a 50% square wave
// at each terminal count. A newly written divisor waits in a pending slot
// and is swapped in only at a period boundary so sclk never glitches.
// Ports:
//   clk, reset   : system clock, asynchronous active-high reset
//   en           : run enable for this channel
//   sync_clr     : phase-align strobe shared by all channels
//   wr, wr_div   : divisor write strobe (already decoded) and value
//   sclk, tick   : registered square wave and terminal-count strobe
//   pending      : a written divisor has not yet been applied
module clkdiv_channel
  import prog_clkdiv_pkg::*;
#(
  parameter int CNT_W       = 32,
  parameter int DEFAULT_DIV = 50000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sync_clr,
  input  logic             wr,
  input  logic [CNT_W-1:0] wr_div,
  output logic             sclk,
  output logic             tick,
  output logic             pending
);

  localparam logic [CNT_W-1:0] DIV_RST   = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] DIV_MIN_W = CNT_W'(DIV_CLAMP);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_act_q, div_act_d;
  logic [CNT_W-1:0] div_pend_q, div_pend_d;
  logic             pend_q, pend_d;
  logic             sclk_q, sclk_d;
  logic             tick_q, tick_d;

  logic [CNT_W-1:0] div_eff;
  logic [CNT_W-1:0] term;
  logic             apply;

  always_comb begin
    cnt_d      = cnt_q;
    div_act_d  = div_act_q;
    div_pend_d = div_pend_q;
    pend_d     = pend_q;
    sclk_d     = sclk_q;
    tick_d     = 1'b0;
    apply      = 1'b0;

    // A zero divisor is clamped so that terminal count never underflows.
    div_eff = (div_act_q < DIV_MIN_W) ? DIV_MIN_W : div_act_q;
    term    = div_eff - DIV_MIN_W;

    if (sync_clr || !en) begin
      // Both park the channel at the start of a period, which is also a
      // safe moment to swap in a waiting divisor.
      cnt_d  = '0;
      sclk_d = 1'b0;
      apply  = pend_q;
    end else if (cnt_q == term) begin
      cnt_d  = '0;
      tick_d = 1'b1;
      sclk_d = ~sclk_q;
      apply  = pend_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    if (apply) begin
      div_act_d = div_pend_q;
      pend_d    = 1'b0;
    end

    // A write in the same cycle as an application lands after it, so the
    // new value stays pending for the next boundary.
    if (wr) begin
      div_pend_d = wr_div;
      pend_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      div_act_q  <= DIV_RST;
      div_pend_q <= DIV_RST;
      pend_q     <= 1'b0;
      sclk_q     <= 1'b0;
      tick_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      div_act_q  <= div_act_d;
      div_pend_q <= div_pend_d;
      pend_q     <= pend_d;
      sclk_q     <= sclk_d;
      tick_q     <= tick_d;
    end
  end

  assign sclk    = sclk_q;
  assign tick    = tick_q;
  assign pending = pend_q;

endmodule

// File: rtl/prog_clock_divider.sv
// Programmable multi-channel clock divider. Instantiates NUM_CH independent
// divider channels and routes the divisor write strobe to the addressed
// channel; writes to indices at or beyond NUM_CH are dropped.
// Ports:
//   clk, reset    : system clock, asynchronous active-high reset
//   ch_en         : per-channel run enable
//   sync_clr      : restart all channels at phase zero
//   cfg_wr        : divisor write strobe (one cycle)
//   cfg_ch        : channel index for cfg_wr
//   cfg_div       : divisor value for cfg_wr
//   sclk          : per-channel square wave, period 2*div
//   tick          : per-channel one-cycle strobe, once every div cycles
//   cfg_pending   : per-channel written divisor not yet applied
module prog_clock_divider
  import prog_clkdiv_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 32,
  parameter int DEFAULT_DIV = 50000000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_CH-1:0]   ch_en,
  input  logic                sync_clr,
  input  logic                cfg_wr,
  input  logic [CH_IDX_W-1:0] cfg_ch,
  input  logic [CNT_W-1:0]    cfg_div,
  output logic [NUM_CH-1:0]   sclk,
  output logic [NUM_CH-1:0]   tick,
  output logic [NUM_CH-1:0]   cfg_pending
);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr_sel;
    assign wr_sel = cfg_wr && (cfg_ch == CH_IDX_W'(i));

    clkdiv_channel #(
      .CNT_W       (CNT_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .en       (ch_en[i]),
      .sync_clr (sync_clr),
      .wr       (wr_sel),
      .wr_div   (cfg_div),
      .sclk     (sclk[i]),
      .tick     (tick[i]),
      .pending  (cfg_pending[i])
    );
  end

endmodule

// File: tb/tb_prog_clock_divider.sv
module tb_prog_clock_divider;
  localparam int NUM_CH      = 4;
  localparam int CNT_W       = 16;
  localparam int DEFAULT_DIV = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NUM_CH-1:0] ch_en = '0;
  logic              sync_clr = 1'b0;
  logic              cfg_wr = 1'b0;
  logic [3:0]        cfg_ch = '0;
  logic [CNT_W-1:0]  cfg_div = '0;
  logic [NUM_CH-1:0] sclk;
  logic [NUM_CH-1:0] tick;
  logic [NUM_CH-1:0] cfg_pending;

  prog_clock_divider #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (DEFAULT_DIV)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ch_en       (ch_en),
    .sync_clr    (sync_clr),
    .cfg_wr      (cfg_wr),
    .cfg_ch      (cfg_ch),
    .cfg_div     (cfg_div),
    .sclk        (sclk),
    .tick        (tick),
    .cfg_pending (cfg_pending)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    failures = 0;
  string phase = "init";

  // Reference: per channel, cycles elapsed in the current period, the
  // divisor governing it, a waiting divisor, and the square-wave level.
  int m_elapsed [NUM_CH];
  int m_div     [NUM_CH];
  int m_wait    [NUM_CH];
  bit m_waiting [NUM_CH];
  bit m_tick    [NUM_CH];
  bit m_sclk    [NUM_CH];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_elapsed[i] = 0;
      m_div[i]     = DEFAULT_DIV;
      m_wait[i]    = DEFAULT_DIV;
      m_waiting[i] = 1'b0;
      m_tick[i]    = 1'b0;
      m_sclk[i]    = 1'b0;
    end
  endtask

  task automatic model_step(input logic [NUM_CH-1:0] en, input bit clr, input bit wr,
                            input int ch, input int dv);
    for (int i = 0; i < NUM_CH; i++) begin
      int period;
      bit boundary;
      period   = (m_div[i] == 0) ? 1 : m_div[i];
      boundary = 1'b0;
      m_tick[i] = 1'b0;
      if (clr || !en[i]) begin
        m_elapsed[i] = 0;
        m_sclk[i]    = 1'b0;
        boundary     = 1'b1;
      end else if (m_elapsed[i] + 1 >= period) begin
        m_elapsed[i] = 0;
        m_tick[i]    = 1'b1;
        m_sclk[i]    = !m_sclk[i];
        boundary     = 1'b1;
      end else begin
        m_elapsed[i] = m_elapsed[i] + 1;
      end
      if (boundary && m_waiting[i]) begin
        m_div[i]     = m_wait[i];
        m_waiting[i] = 1'b0;
      end
      if (wr && ch == i) begin
        m_wait[i]    = dv;
        m_waiting[i] = 1'b1;
      end
    end
  endtask

  task automatic check_outputs();
    logic [NUM_CH-1:0] es, et, ep;
    for (int i = 0; i < NUM_CH; i++) begin
      es[i] = m_sclk[i];
      et[i] = m_tick[i];
      ep[i] = m_waiting[i];
    end
    check_val({phase, ".sclk"}, 32'(sclk), 32'(es));
    check_val({phase, ".tick"}, 32'(tick), 32'(et));
    check_val({phase, ".pending"}, 32'(cfg_pending), 32'(ep));
  endtask

  // Called just after a falling edge: drive inputs, advance the model over
  // the next rising edge, then compare on the following falling edge.
  task automatic cycle(input logic [NUM_CH-1:0] en, input bit clr, input bit wr,
                       input int ch, input int dv);
    ch_en    = en;
    sync_clr = clr;
    cfg_wr   = wr;
    cfg_ch   = 4'(ch);
    cfg_div  = CNT_W'(dv);
    model_step(en, clr, wr, ch, dv);
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input logic [NUM_CH-1:0] en, input int n);
    for (int k = 0; k < n; k++) cycle(en, 1'b0, 1'b0, 0, 0);
  endtask

  initial begin
    model_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    phase = "reset";
    check_outputs();

    phase = "default_div";
    idle('1, 20);

    phase = "wr_ch1_div3";
    idle('1, 2);
    cycle('1, 1'b0, 1'b1, 1, 3);
    idle('1, 20);

    phase = "div0_div1";
    cycle('1, 1'b0, 1'b1, 0, 0);
    cycle('1, 1'b0, 1'b1, 3, 1);
    idle('1, 12);

    phase = "ch2_disable";
    for (int k = 0; k < 8 && m_elapsed[2] != 2; k++) cycle('1, 1'b0, 1'b0, 0, 0);
    check_val("ch2_at_cnt2", 32'(m_elapsed[2]), 32'd2);
    idle(4'b1011, 3);
    idle('1, 10);

    phase = "sync_clr_3456";
    cycle('1, 1'b0, 1'b1, 0, 3);
    cycle('1, 1'b0, 1'b1, 1, 4);
    cycle('1, 1'b0, 1'b1, 2, 5);
    cycle('1, 1'b0, 1'b1, 3, 6);
    idle('1, 2);
    cycle('1, 1'b1, 1'b0, 0, 0);
    idle('1, 14);

    phase = "clr_with_wr";
    cycle('1, 1'b1, 1'b1, 2, 7);
    idle('1, 10);

    phase = "bad_ch";
    cycle('1, 1'b0, 1'b1, 9, 2);
    cycle('1, 1'b0, 1'b1, 15, 2);
    idle('1, 4);

    phase = "random";
    for (int k = 0; k < 600; k++) begin
      logic [NUM_CH-1:0] en;
      for (int i = 0; i < NUM_CH; i++) en[i] = ($urandom_range(0, 9) != 0);
      cycle(en, ($urandom_range(0, 29) == 0), ($urandom_range(0, 5) == 0),
            int'($urandom_range(0, 15)), int'($urandom_range(0, 7)));
    end

    phase = "async_reset";
    cycle('1, 1'b0, 1'b1, 2, 9);
    check_val("pre_reset.pending2", 32'(cfg_pending[2]), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check_val("async_reset.sclk", 32'(sclk), 32'd0);
    check_val("async_reset.tick", 32'(tick), 32'd0);
    check_val("async_reset.pending", 32'(cfg_pending), 32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_outputs();
    phase = "after_reset";
    idle('1, 20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/prog_clock_divider.md
PROG_CLOCK_DIVIDER -- requirements
Module: prog_clock_divider

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent divider channels (1..16).
REQ-002 Parameter CNT_W, default 32: divisor and counter width in bits.
REQ-003 Parameter DEFAULT_DIV, default 50000000: divisor loaded into every channel at reset.
REQ-004 clk  in  1  single system clock; all logic on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 ch_en  in  NUM_CH  per-channel run enable.
REQ-007 sync_clr  in  1  synchronous phase-align strobe for all channels.
REQ-008 cfg_wr  in  1  divisor write strobe, one cycle.
REQ-009 cfg_ch  in  4  target channel index for cfg_wr.
REQ-010 cfg_div  in  CNT_W  new divisor value for cfg_wr.
REQ-011 sclk  out  NUM_CH  per-channel square wave, period 2*div cycles, 50% duty.
REQ-012 tick  out  NUM_CH  per-channel one-cycle strobe, once every div cycles.
REQ-013 cfg_pending  out  NUM_CH  high while a written divisor awaits application.

Function
REQ-014 Each channel SHALL hold an active divisor (div_act), a pending divisor (div_pend), a pending flag, and a counter cnt of width CNT_W.
REQ-015 An effective divisor of 0 SHALL be treated as 1; the terminal count is therefore max(div_act,1)-1.
REQ-016 While ch_en[i]=1 and cnt != terminal, cnt SHALL increment by 1 each cycle and tick[i] SHALL be 0 on the next edge.
REQ-017 While ch_en[i]=1 and cnt == terminal, the next edge SHALL set cnt to 0, set tick[i] to 1 for exactly one cycle, and invert sclk[i].
REQ-018 div_act=1 SHALL give tick[i] continuously high and sclk[i] toggling every cycle (clk/2).
REQ-019 cfg_wr with cfg_ch < NUM_CH SHALL load div_pend and set cfg_pending[cfg_ch] on the next edge; cfg_ch >= NUM_CH SHALL be ignored.
REQ-020 A pending divisor SHALL move to div_act on the terminal-count edge of that channel (glitch-free), clearing cfg_pending in the same edge; the new period starts with cnt=0.
REQ-021 If the channel is disabled, a pending divisor SHALL be applied on the edge after the write.
REQ-022 cfg_wr coinciding with the terminal-count edge SHALL be deferred to the following period; the old pending value is then overwritten and still applied.
REQ-023 A second cfg_wr to the same channel before application SHALL overwrite div_pend (last write wins).
REQ-024 ch_en[i]=0 SHALL force, on the next edge, cnt=0, tick[i]=0, sclk[i]=0; re-enable restarts a full period from cnt=0.
REQ-025 sync_clr=1 SHALL, on the next edge, force cnt=0, tick=0, sclk=0 in all channels and take priority over counting; pending divisors SHALL be applied immediately.
REQ-026 sync_clr and cfg_wr in the same cycle: the write SHALL land in div_pend and remain pending.
REQ-027 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-028 reset=1 SHALL asynchronously set cnt=0, sclk=0, tick=0, cfg_pending=0, div_act=div_pend=DEFAULT_DIV for every channel.
REQ-029 Reset deassertion SHALL be honoured on any edge; the first tick SHALL occur DEFAULT_DIV cycles after the first enabled edge.
REQ-030 Reset asserted mid-period SHALL discard any pending divisor.

Structure
REQ-031 A shared package prog_clkdiv_pkg SHALL hold CH_IDX_W (=4) and the divisor-zero clamp constant.
REQ-032 One sub-module, clkdiv_channel, SHALL implement one channel (REQ-014..REQ-027); the top SHALL generate NUM_CH instances and decode cfg_wr/cfg_ch.

Verification
REQ-033 DEFAULT_DIV=4, ch_en=1 after reset -> tick every 4 cycles, sclk period 8, duty 4/4.
REQ-034 cfg_wr ch1 div=3 mid-period -> cfg_pending[1] high until ch1 terminal count, then tick spacing 3, other channels unchanged.
REQ-035 cfg_div=0 and cfg_div=1 -> tick stuck high, sclk toggles every cycle.
REQ-036 ch_en[2] dropped at cnt=2 then raised -> sclk[2]=0 next edge, first tick 4 cycles after re-enable.
REQ-037 sync_clr pulsed with channels at divisors 3,4,5,6 -> all cnt=0/sclk=0 same edge, ticks realign at 3,4,5,6 cycles later.
REQ-038 reset asserted between clock edges mid-period -> outputs 0 immediately, cfg_pending cleared, divisor back to 4.
